pipe_skid_stage: RTL and testbench

//  Elastic pipeline stage: the consumer-side counterpart of the enabled register.

---
 rtl/pipe_skid_stage_if.sv | 32 +++
 rtl/pipe_skid_stage.sv | 104 ++++++++++
 tb/tb_pipe_skid_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// ============================================================================
// pipe_skid_stage_if : valid/ready handshake bundle around one elastic stage
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_skid_stage_if #(
  parameter int WIDTH = 8
);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occupancy;

  // Environment side: produces upstream words and consumes downstream ones.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // Stage side.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// pipe_skid_stage : two-entry elastic stage (main + skid) with registered ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
  parameter int WIDTH = 8
) (
  input  wire                 clk,
  input  wire                 reset,
  pipe_skid_stage_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_from_in;
  logic             w_main_from_skid;
  logic             w_skid_from_in;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = (r_state != ST_EMPTY) & bus.out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_from_in = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_from_in = 1'b1;
        end else if (w_in_fire) begin
          w_skid_from_in = 1'b1;
          w_state_nxt    = ST_FULL;
        end else if (w_out_fire) begin
          w_state_nxt    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush drops whatever is held and any word arriving on the same edge;
    // data registers keep their contents, only occupancy is cleared.
    if (bus.flush) begin
      w_state_nxt      = ST_EMPTY;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_main_from_in) begin
        r_main <= bus.in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= bus.in_data;
      end
    end
  end

  // Ready is a flop output; reset only gates it so upstream sees 0 while held.
  assign bus.in_ready  = r_in_ready & ~reset;
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_data  = r_main;
  assign bus.occupancy = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// tb_pipe_skid_stage : directed vectors plus a randomized queue-model soak
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  pipe_skid_stage_if #(.WIDTH(WIDTH)) bus ();

  pipe_skid_stage #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set afterwards apply
  // to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic check_state(input string tag, input logic ov, input logic [7:0] od,
                             input logic [1:0] occ, input logic ir);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
    if (ov) check({tag, "_out_data"}, 32'(bus.out_data), 32'(od));
    check({tag, "_occupancy"}, 32'(bus.occupancy), 32'(occ));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(ir));
  endtask

  logic [7:0] q[$];
  logic [7:0] prev_data;
  logic       prev_stall;
  logic       in_fire;
  logic       out_fire;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // 1. reset and idle
    tick();
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    check("rst_in_ready_held", 32'(bus.in_ready), 32'd0);
    tick();
    check_state("idle", 1'b0, 8'h00, 2'd0, 1'b1);
    check("idle_out_data_zero", 32'(bus.out_data), 32'd0);

    // 2. streaming at full rate
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    tick();
    check_state("s11", 1'b1, 8'h11, 2'd1, 1'b1);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    tick();
    check_state("s22", 1'b1, 8'h22, 2'd1, 1'b1);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    tick();
    check_state("s33", 1'b1, 8'h33, 2'd1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_state("s_drain", 1'b0, 8'h00, 2'd0, 1'b1);

    // 3. backpressure fills skid, A3 held off until a slot frees
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    tick();
    check_state("a1", 1'b1, 8'hA1, 2'd1, 1'b1);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    tick();
    check_state("a2_full", 1'b1, 8'hA1, 2'd2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0, 1'b0);
    tick();
    check_state("a3_held", 1'b1, 8'hA1, 2'd2, 1'b0);
    drive(1'b1, 8'hA3, 1'b1, 1'b0);
    tick();
    check_state("a_pop1", 1'b1, 8'hA2, 2'd1, 1'b1);
    tick();
    check_state("a_pop2", 1'b1, 8'hA3, 2'd1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_state("a_drain", 1'b0, 8'h00, 2'd0, 1'b1);

    // 4. flush while full, incoming B3 discarded
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    tick();
    check_state("b_full", 1'b1, 8'hB1, 2'd2, 1'b0);
    drive(1'b1, 8'hB3, 1'b0, 1'b1);
    tick();
    check_state("b_flush", 1'b0, 8'h00, 2'd0, 1'b1);
    check("b_flush_data_kept", 32'(bus.out_data), 32'hB1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_state("b_after", 1'b0, 8'h00, 2'd0, 1'b1);

    // flush with upstream offering a word from EMPTY/ONE also discards it
    drive(1'b1, 8'hB4, 1'b1, 1'b1);
    tick();
    check_state("b_flush_in", 1'b0, 8'h00, 2'd0, 1'b1);

    // 5. reset while full with active handshakes
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hC2, 1'b0, 1'b0);
    tick();
    check_state("c_full", 1'b1, 8'hC1, 2'd2, 1'b0);
    reset = 1'b1;
    drive(1'b1, 8'hC3, 1'b1, 1'b0);
    tick();
    check_state("c_reset", 1'b0, 8'h00, 2'd0, 1'b0);
    check("c_reset_data_zero", 32'(bus.out_data), 32'd0);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_state("c_post", 1'b0, 8'h00, 2'd0, 1'b1);
    tick();
    check_state("c_no_stale", 1'b0, 8'h00, 2'd0, 1'b1);

    // 6. randomized soak against a reference queue
    q.delete();
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), 1'b0);
      if (prev_stall) check("rnd_stable", 32'(bus.out_data), 32'(prev_data));
      in_fire  = bus.in_valid & bus.in_ready;
      out_fire = bus.out_valid & bus.out_ready;
      if (out_fire) begin
        if (q.size() == 0) check("rnd_unexpected_out", 32'd1, 32'd0);
        else               check("rnd_order", 32'(bus.out_data), 32'(q.pop_front()));
      end
      if (in_fire) q.push_back(bus.in_data);
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      tick();
      check("rnd_occupancy", 32'(bus.occupancy), 32'(q.size()));
      check("rnd_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
